// File: rtl/pipemem.sv
// MEM-stage data memory for a 5-stage pipeline with byte/half/word lanes and misalignment detection.
// Define PIPEMEM_WAITSTATE_EN to add a WAIT-cycle stall FSM; otherwise every access completes in one cycle.
module pipemem #(
   parameter int ADDR_W = 8,
   parameter int WAIT   = 2
) (
   input  logic        clk,
   input  logic        clrn,
   input  logic        mwmem,
   input  logic        mrmem,
   input  logic [1:0]  msize,
   input  logic        msext,
   input  logic [31:0] malu,
   input  logic [31:0] mb,
   output logic [31:0] mmo,
   output logic        mstall,
   output logic        maddrerr
);

   localparam int DEPTH = 1 << ADDR_W;

   logic [31:0]       mem [DEPTH];
   logic [ADDR_W-1:0] word_idx;
   logic [1:0]        lane;
   logic              aligned;
   logic              req;
   logic              access;
   logic              store_acc;
   logic              load_acc;
   logic              complete;
   logic              commit;
   logic              mem_we;
   logic [31:0]       rd_word;
   logic [31:0]       wr_word;
   logic [31:0]       load_data;
   logic [7:0]        byte_sel;
   logic [15:0]       half_sel;
   logic [31-ADDR_W-2:0] unused_addr_bits;

   assign word_idx         = malu[ADDR_W+1:2];
   assign lane             = malu[1:0];
   assign unused_addr_bits = malu[31:ADDR_W+2];

   always_comb begin
      aligned = 1'b1;
      case (msize)
         2'b00:   aligned = 1'b1;
         2'b01:   aligned = ~lane[0];
         default: aligned = (lane == 2'b00);
      endcase
   end

   // A simultaneous store and load request is treated purely as a store.
   assign req       = mrmem | mwmem;
   assign access    = req & aligned;
   assign store_acc = access & mwmem;
   assign load_acc  = access & mrmem & ~mwmem;
   assign maddrerr  = req & ~aligned;

   assign rd_word  = mem[word_idx];
   assign byte_sel = rd_word[{lane, 3'b000} +: 8];
   assign half_sel = lane[1] ? rd_word[31:16] : rd_word[15:0];

   always_comb begin
      load_data = rd_word;
      case (msize)
         2'b00:   load_data = {{24{msext & byte_sel[7]}}, byte_sel};
         2'b01:   load_data = {{16{msext & half_sel[15]}}, half_sel};
         default: load_data = rd_word;
      endcase
   end

   // Read-modify-write merge so sub-word stores leave the other lanes intact.
   always_comb begin
      wr_word = rd_word;
      case (msize)
         2'b00: wr_word[{lane, 3'b000} +: 8] = mb[7:0];
         2'b01: begin
            if (lane[1]) begin
               wr_word[31:16] = mb[15:0];
            end else begin
               wr_word[15:0] = mb[15:0];
            end
         end
         default: wr_word = mb;
      endcase
   end

`ifdef PIPEMEM_WAITSTATE_EN
   typedef enum logic {
      IDLE,
      BUSY
   } state_t;

   state_t     state_q;
   state_t     state_d;
   logic [3:0] cnt_q;
   logic [3:0] cnt_d;
   logic       stall_raw;

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      stall_raw = 1'b0;
      complete  = 1'b0;
      case (state_q)
         IDLE: begin
            if (access) begin
               stall_raw = 1'b1;
               cnt_d     = 4'(WAIT - 1);
               state_d   = BUSY;
            end
         end
         BUSY: begin
            if (cnt_q != 4'd0) begin
               stall_raw = 1'b1;
               cnt_d     = cnt_q - 4'd1;
            end else begin
               complete = 1'b1;
               state_d  = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign mstall = stall_raw & clrn;
`else
   logic [3:0] unused_wait;

   assign unused_wait = 4'(WAIT);
   assign complete    = 1'b1;
   assign mstall      = 1'b0;
`endif

   // Reset masks completion so neither load data nor a store escape while clrn is low.
   assign commit = complete & clrn;
   assign mem_we = commit & store_acc;
   assign mmo    = (commit & load_acc) ? load_data : 32'd0;

   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[word_idx] <= wr_word;
      end
   end

endmodule

// File: tb/tb_pipemem.sv
// Testbench for pipemem: table vectors, reset corner cases and random accesses checked
// against a byte-addressed reference memory.
module tb_pipemem;

`ifdef PIPEMEM_WAITSTATE_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 0;
`endif

   logic        clk;
   logic        clrn;
   logic        mwmem;
   logic        mrmem;
   logic [1:0]  msize;
   logic        msext;
   logic [31:0] malu;
   logic [31:0] mb;
   logic [31:0] mmo;
   logic        mstall;
   logic        maddrerr;

   int compares;
   int errors;

   logic [7:0] mbytes [1024];

   typedef struct {
      logic        wr;
      logic        rd;
      logic [1:0]  size;
      logic        sext;
      logic [31:0] addr;
      logic [31:0] data;
      logic [31:0] exp_mmo;
      logic        exp_err;
      string       name;
   } vec_t;

   vec_t vecs[$];

   pipemem #(.ADDR_W(8), .WAIT(2)) dut (
      .clk      (clk),
      .clrn     (clrn),
      .mwmem    (mwmem),
      .mrmem    (mrmem),
      .msize    (msize),
      .msext    (msext),
      .malu     (malu),
      .mb       (mb),
      .mmo      (mmo),
      .mstall   (mstall),
      .maddrerr (maddrerr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: actual timeout required completion");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic int bytesOf(input logic [1:0] size);
      return (size == 2'd0) ? 1 : ((size == 2'd1) ? 2 : 4);
   endfunction

   function automatic logic alignedRule(input logic [1:0] size, input logic [31:0] addr);
      return (int'(addr[1:0]) % bytesOf(size)) == 0;
   endfunction

   function automatic logic [31:0] modelLoad(input logic [1:0] size, input logic sext,
                                             input logic [31:0] addr);
      int          n    = bytesOf(size);
      int          base = int'(addr[9:0]);
      logic [31:0] v    = 32'd0;
      for (int i = 0; i < n; i++) begin
         v = v | (32'(mbytes[base + i]) << (8 * i));
      end
      if (sext && n < 4 && v[8 * n - 1]) begin
         v = v | (32'hFFFF_FFFF << (8 * n));
      end
      return v;
   endfunction

   task automatic modelStore(input logic [1:0] size, input logic [31:0] addr,
                             input logic [31:0] data);
      int n    = bytesOf(size);
      int base = int'(addr[9:0]);
      for (int i = 0; i < n; i++) begin
         mbytes[base + i] = 8'(data >> (8 * i));
      end
   endtask

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      compares++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: actual %h required %h", name, actual, expected);
      end
   endtask

   // Drives one request and holds it until the completion cycle, counting stalled cycles.
   task automatic applyStimulus(input logic wr, input logic rd, input logic [1:0] size,
                                input logic sext, input logic [31:0] addr,
                                input logic [31:0] data, output logic [31:0] got_mmo,
                                output logic got_err, output int got_stalls);
      logic done;
      mwmem      = wr;
      mrmem      = rd;
      msize      = size;
      msext      = sext;
      malu       = addr;
      mb         = data;
      got_stalls = 0;
      got_mmo    = 32'd0;
      got_err    = 1'b0;
      done       = 1'b0;
      for (int c = 0; c < 40 && !done; c++) begin
         @(negedge clk);
         if (mstall) begin
            got_stalls++;
            checkOutput("mmo_during_stall", mmo, 32'd0);
         end else begin
            got_mmo = mmo;
            got_err = maddrerr;
            done    = 1'b1;
         end
         @(posedge clk);
         #1;
      end
      if (!done) begin
         checkOutput("completion_timeout", 32'd0, 32'd1);
      end
   endtask

   task automatic runAccess(input logic wr, input logic rd, input logic [1:0] size,
                            input logic sext, input logic [31:0] addr, input logic [31:0] data,
                            output logic [31:0] got_mmo, output logic got_err);
      logic        ok_align;
      logic        exp_err;
      logic [31:0] exp_mmo;
      int          exp_stall;
      int          got_stall;
      ok_align  = alignedRule(size, addr);
      exp_err   = (wr | rd) & ~ok_align;
      exp_stall = ((wr | rd) && ok_align) ? LAT : 0;
      exp_mmo   = (rd && !wr && ok_align) ? modelLoad(size, sext, addr) : 32'd0;
      applyStimulus(wr, rd, size, sext, addr, data, got_mmo, got_err, got_stall);
      checkOutput("stall_cycles", 32'(got_stall), 32'(exp_stall));
      checkOutput("mmo_model", got_mmo, exp_mmo);
      checkOutput("maddrerr_model", {31'b0, got_err}, {31'b0, exp_err});
      if (wr && ok_align) begin
         modelStore(size, addr, data);
      end
   endtask

   initial begin
      logic [31:0] got_mmo;
      logic        got_err;
      logic        wr;
      logic        rd;
      logic [1:0]  size;
      logic [31:0] addr;
      int          op;

      compares = 0;
      errors   = 0;

      // Reset: outputs quiet while maddrerr still follows the inputs.
      clrn  = 1'b0;
      mwmem = 1'b0;
      mrmem = 1'b1;
      msize = 2'd2;
      msext = 1'b0;
      malu  = 32'h11;
      mb    = 32'd0;
      #12;
      checkOutput("reset_mstall", {31'b0, mstall}, 32'd0);
      checkOutput("reset_mmo", mmo, 32'd0);
      checkOutput("reset_maddrerr_mis", {31'b0, maddrerr}, 32'd1);
      malu = 32'h10;
      #4;
      checkOutput("reset_mstall_aligned", {31'b0, mstall}, 32'd0);
      checkOutput("reset_mmo_aligned", mmo, 32'd0);
      checkOutput("reset_maddrerr_aligned", {31'b0, maddrerr}, 32'd0);
      mrmem = 1'b0;
      @(negedge clk);
      clrn = 1'b1;
      @(posedge clk);
      #1;

      vecs.push_back('{1'b1, 1'b0, 2'd2, 1'b0, 32'h10, 32'h1234_5678, 32'h0, 1'b0, "sw_0x10"});
      vecs.push_back('{1'b0, 1'b1, 2'd2, 1'b0, 32'h10, 32'h0, 32'h1234_5678, 1'b0, "lw_0x10"});
      vecs.push_back('{1'b1, 1'b0, 2'd0, 1'b0, 32'h13, 32'hCDEF_01AB, 32'h0, 1'b0, "sb_0x13"});
      vecs.push_back('{1'b0, 1'b1, 2'd2, 1'b0, 32'h10, 32'h0, 32'hAB34_5678, 1'b0, "lw_after_sb"});
      vecs.push_back('{1'b0, 1'b1, 2'd0, 1'b1, 32'h13, 32'h0, 32'hFFFF_FFAB, 1'b0, "lb_0x13"});
      vecs.push_back('{1'b0, 1'b1, 2'd0, 1'b0, 32'h13, 32'h0, 32'h0000_00AB, 1'b0, "lbu_0x13"});
      vecs.push_back('{1'b1, 1'b0, 2'd1, 1'b0, 32'h12, 32'h7777_8001, 32'h0, 1'b0, "sh_0x12"});
      vecs.push_back('{1'b0, 1'b1, 2'd1, 1'b1, 32'h12, 32'h0, 32'hFFFF_8001, 1'b0, "lh_0x12"});
      vecs.push_back('{1'b0, 1'b1, 2'd1, 1'b0, 32'h12, 32'h0, 32'h0000_8001, 1'b0, "lhu_0x12"});
      vecs.push_back('{1'b0, 1'b1, 2'd2, 1'b0, 32'h10, 32'h0, 32'h8001_5678, 1'b0, "lw_after_sh"});
      vecs.push_back('{1'b0, 1'b1, 2'd2, 1'b0, 32'h11, 32'h0, 32'h0, 1'b1, "lw_misaligned"});
      vecs.push_back('{1'b1, 1'b0, 2'd1, 1'b0, 32'h13, 32'hFFFF_FFFF, 32'h0, 1'b1, "sh_misaligned"});
      vecs.push_back('{1'b0, 1'b1, 2'd2, 1'b0, 32'h10, 32'h0, 32'h8001_5678, 1'b0, "lw_unchanged"});
      vecs.push_back('{1'b0, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 32'h0, 1'b0, "idle"});
      vecs.push_back('{1'b1, 1'b1, 2'd2, 1'b0, 32'h14, 32'h1122_3344, 32'h0, 1'b0, "sw_lw_same"});
      vecs.push_back('{1'b0, 1'b1, 2'd3, 1'b0, 32'h14, 32'h0, 32'h1122_3344, 1'b0, "lw_size3"});
      vecs.push_back('{1'b0, 1'b1, 2'd3, 1'b0, 32'h12, 32'h0, 32'h0, 1'b1, "lw3_misaligned"});
      vecs.push_back('{1'b0, 1'b1, 2'd0, 1'b1, 32'h12, 32'h0, 32'h0000_0001, 1'b0, "lb_positive"});
      vecs.push_back('{1'b0, 1'b1, 2'd1, 1'b0, 32'h10, 32'h0, 32'h0000_5678, 1'b0, "lhu_low"});
      vecs.push_back('{1'b1, 1'b0, 2'd1, 1'b0, 32'h16, 32'hCAFE_1234, 32'h0, 1'b0, "sh_upper"});
      vecs.push_back('{1'b0, 1'b1, 2'd2, 1'b0, 32'h14, 32'h0, 32'h1234_3344, 1'b0, "lw_after_sh_hi"});
      vecs.push_back('{1'b0, 1'b1, 2'd1, 1'b1, 32'h16, 32'h0, 32'h0000_1234, 1'b0, "lh_positive"});
      vecs.push_back('{1'b1, 1'b0, 2'd2, 1'b0, 32'h4, 32'h0000_0055, 32'h0, 1'b0, "sw_0x4"});
      vecs.push_back('{1'b0, 1'b1, 2'd2, 1'b0, 32'h4, 32'h0, 32'h0000_0055, 1'b0, "lw_0x4_b2b"});

      foreach (vecs[i]) begin
         runAccess(vecs[i].wr, vecs[i].rd, vecs[i].size, vecs[i].sext, vecs[i].addr,
                   vecs[i].data, got_mmo, got_err);
         checkOutput({vecs[i].name, "_mmo"}, got_mmo, vecs[i].exp_mmo);
         checkOutput({vecs[i].name, "_err"}, {31'b0, got_err}, {31'b0, vecs[i].exp_err});
      end

`ifdef PIPEMEM_WAITSTATE_EN
      // Reset in the first BUSY cycle must abandon the pending store.
      runAccess(1'b1, 1'b0, 2'd2, 1'b0, 32'h20, 32'h0BAD_F00D, got_mmo, got_err);
      mwmem = 1'b1;
      mrmem = 1'b0;
      msize = 2'd2;
      malu  = 32'h20;
      mb    = 32'hDEAD_BEEF;
      @(negedge clk);
      checkOutput("abort_first_stall", {31'b0, mstall}, 32'd1);
      @(posedge clk);
      #2;
      clrn = 1'b0;
      #1;
      checkOutput("abort_mstall_now", {31'b0, mstall}, 32'd0);
      checkOutput("abort_mmo_now", mmo, 32'd0);
      mwmem = 1'b0;
      @(negedge clk);
      clrn = 1'b1;
      @(posedge clk);
      #1;
      runAccess(1'b0, 1'b1, 2'd2, 1'b0, 32'h20, 32'h0, got_mmo, got_err);
      checkOutput("abort_old_value", got_mmo, 32'h0BAD_F00D);
`endif

      for (int w = 0; w < 256; w++) begin
         runAccess(1'b1, 1'b0, 2'd2, 1'b0, 32'(w * 4), $urandom(), got_mmo, got_err);
      end

      for (int k = 0; k < 400; k++) begin
         op   = int'($urandom_range(0, 9));
         wr   = (op <= 3) || (op == 8);
         rd   = (op >= 4) && (op <= 8);
         size = 2'($urandom_range(0, 3));
         addr = $urandom();
         if ($urandom_range(0, 3) != 0) begin
            addr = addr & ~(32'(bytesOf(size)) - 32'd1);
         end
         runAccess(wr, rd, size, 1'($urandom_range(0, 1)), addr, $urandom(), got_mmo, got_err);
      end

      mwmem = 1'b0;
      mrmem = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, errors);
      $finish;
   end

endmodule
